// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, line levels and default oversampling.
package uart_pkg;

    localparam int OVS_DEFAULT       = 16;
    localparam int DATA_BITS_DEFAULT = 8;

    typedef logic [2:0] state_t;

    localparam state_t IDLE  = 3'd0;
    localparam state_t START = 3'd1;
    localparam state_t DATA  = 3'd2;
    localparam state_t STOP  = 3'd3;
    localparam state_t BREAK = 3'd4;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;

endpackage

// File: rtl/bit_sync.sv
// Two-flop synchronizer for a single asynchronous bit; 2 clk latency, no backpressure.
// RST_VAL sets the flop reset value so an idle-high line does not look active out of reset.
module bit_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic n_rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver; rx_valid rises on the rxen tick that samples a good stop bit.
// No backpressure: a byte completing while rx_valid is high overwrites rx_data and sets sticky overrun.
module uart_rx
    import uart_pkg::*;
#(
    parameter int OVS       = OVS_DEFAULT,
    parameter int DATA_BITS = DATA_BITS_DEFAULT
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 rxd,
    input  logic                 rxen,
    input  logic                 rx_ack,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 rx_busy
);

    localparam int TW = $clog2(OVS);
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [TW-1:0] TICK_MID = TW'(OVS / 2 - 1);
    localparam logic [TW-1:0] TICK_END = TW'(OVS - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    logic rxd_s;

    bit_sync #(
        .RST_VAL(LINE_IDLE)
    ) u_rxd_sync (
        .clk  (clk),
        .n_rst(n_rst),
        .d_i  (rxd),
        .q_o  (rxd_s)
    );

    state_t                state_q, state_d;
    logic [TW-1:0]         tick_q, tick_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic [DATA_BITS-1:0]  shift_q, shift_d;
    logic [DATA_BITS-1:0]  rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  overrun_q, overrun_d;
    logic                  frame_err_q, frame_err_d;

    logic tick_clr, tick_inc;
    logic bit_clr, bit_inc;
    logic shift_en;
    logic byte_done;
    logic stop_bad;
    logic busy;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (rxen) begin
            case (state_q)
                IDLE: begin
                    if (rxd_s == START_BIT) state_d = START;
                end
                START: begin
                    if (tick_q == TICK_MID) state_d = (rxd_s == START_BIT) ? DATA : IDLE;
                end
                DATA: begin
                    if (tick_q == TICK_END && bit_q == BIT_LAST) state_d = STOP;
                end
                STOP: begin
                    if (tick_q == TICK_END) state_d = (rxd_s == LINE_IDLE) ? IDLE : BREAK;
                end
                BREAK: begin
                    // A line held low after a bad stop must go high before we rearm.
                    if (rxd_s == LINE_IDLE) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        tick_clr  = 1'b0;
        tick_inc  = 1'b0;
        bit_clr   = 1'b0;
        bit_inc   = 1'b0;
        shift_en  = 1'b0;
        byte_done = 1'b0;
        stop_bad  = 1'b0;
        busy      = (state_q != IDLE);
        if (rxen) begin
            case (state_q)
                IDLE: begin
                    tick_clr = (rxd_s == START_BIT);
                end
                START: begin
                    if (tick_q == TICK_MID) begin
                        tick_clr = 1'b1;
                        bit_clr  = 1'b1;
                    end else begin
                        tick_inc = 1'b1;
                    end
                end
                DATA: begin
                    if (tick_q == TICK_END) begin
                        tick_clr = 1'b1;
                        shift_en = 1'b1;
                        bit_inc  = 1'b1;
                    end else begin
                        tick_inc = 1'b1;
                    end
                end
                STOP: begin
                    if (tick_q == TICK_END) begin
                        tick_clr  = 1'b1;
                        byte_done = (rxd_s == LINE_IDLE);
                        stop_bad  = (rxd_s != LINE_IDLE);
                    end else begin
                        tick_inc = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        tick_d = tick_q;
        if (tick_clr)      tick_d = '0;
        else if (tick_inc) tick_d = tick_q + 1'b1;

        bit_d = bit_q;
        if (bit_clr)      bit_d = '0;
        else if (bit_inc) bit_d = bit_q + 1'b1;

        // Right shift so the first (LSB) bit on the wire ends up in bit 0.
        shift_d = shift_q;
        if (shift_en) shift_d = {rxd_s, shift_q[DATA_BITS-1:1]};

        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        overrun_d   = overrun_q;
        frame_err_d = stop_bad;
        if (byte_done) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
            overrun_d  = !rx_ack && (rx_valid_q || overrun_q);
        end else if (rx_ack && rx_valid_q) begin
            rx_valid_d = 1'b0;
            overrun_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            tick_q      <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            tick_q      <= tick_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;
    assign rx_busy   = busy;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at OVS=16, DATA_BITS=8; rxen ticks every 4th clk.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       rxd;
    logic       rxen;
    logic       rx_ack;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       rx_busy;

    int n_checks = 0;
    int n_pass   = 0;
    int tick_no  = 0;
    int vld_rises = 0;
    int vld_rise_tick = -1;
    int ferr_cnt = 0;
    logic vld_prev = 1'b0;
    int frame_t0 = 0;
    int frame_seq = 0;

    uart_rx #(.OVS(16), .DATA_BITS(8)) dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .rxd      (rxd),
        .rxen     (rxen),
        .rx_ack   (rx_ack),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .frame_err(frame_err),
        .overrun  (overrun),
        .rx_busy  (rx_busy)
    );

    always #5 clk = ~clk;

    // tick_no is bumped when rxen rises, so it names the posedge that will consume the tick.
    initial begin
        rxen = 1'b0;
        forever begin
            repeat (3) @(posedge clk);
            #2 rxen = 1'b1;
            tick_no++;
            @(posedge clk);
            #2 rxen = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rx_valid && !vld_prev) begin
            vld_rises++;
            vld_rise_tick = tick_no;
        end
        vld_prev = rx_valid;
        if (frame_err) ferr_cnt++;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "watchdog");
    end

    task automatic wait_tick();
        @(posedge clk);
        while (!rxen) @(posedge clk);
        @(negedge clk);
    endtask

    // Start is seen by the DUT at frame_t0+1; good stop sample lands on tick frame_t0+153.
    task automatic drive_frame(input logic [7:0] d, input logic stop_bit);
        wait_tick();
        frame_t0 = tick_no;
        frame_seq++;
        rxd = 1'b0;
        repeat (16) wait_tick();
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            repeat (16) wait_tick();
        end
        rxd = stop_bit;
        repeat (16) wait_tick();
    endtask

    task automatic ack_pulse();
        @(negedge clk);
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
    endtask

    task automatic test_reset();
        n_rst = 1'b0; rxd = 1'b1; rx_ack = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (rx_data !== 8'h00) $display("FAIL reset_data: got %h want 00", rx_data); else n_pass++;
        n_checks++; if (rx_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", rx_valid); else n_pass++;
        n_checks++; if (frame_err !== 1'b0) $display("FAIL reset_ferr: got %b want 0", frame_err); else n_pass++;
        n_checks++; if (overrun !== 1'b0) $display("FAIL reset_overrun: got %b want 0", overrun); else n_pass++;
        n_checks++; if (rx_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", rx_busy); else n_pass++;
        n_rst = 1'b1;
        repeat (10) wait_tick();
        n_checks++; if (rx_busy !== 1'b0) $display("FAIL idle_busy: got %b want 0", rx_busy); else n_pass++;
    endtask

    task automatic test_basic();
        int ferr0;
        int r0;
        ferr0 = ferr_cnt; r0 = vld_rises;
        drive_frame(8'hA5, 1'b1);
        n_checks++; if (rx_data !== 8'hA5) $display("FAIL basic_data: got %h want a5", rx_data); else n_pass++;
        n_checks++; if (rx_valid !== 1'b1) $display("FAIL basic_valid: got %b want 1", rx_valid); else n_pass++;
        n_checks++; if (vld_rise_tick != frame_t0 + 153) $display("FAIL basic_latency: valid rose at tick %0d want %0d", vld_rise_tick, frame_t0 + 153); else n_pass++;
        n_checks++; if (vld_rises != r0 + 1) $display("FAIL basic_rises: got %0d want %0d", vld_rises, r0 + 1); else n_pass++;
        n_checks++; if (ferr_cnt != ferr0) $display("FAIL basic_ferr: got %0d pulses want 0", ferr_cnt - ferr0); else n_pass++;
        n_checks++; if (rx_busy !== 1'b0) $display("FAIL basic_busy_after: got %b want 0", rx_busy); else n_pass++;
        repeat (20) @(negedge clk);
        n_checks++; if (rx_valid !== 1'b1) $display("FAIL basic_valid_held: got %b want 1", rx_valid); else n_pass++;
        ack_pulse();
        n_checks++; if (rx_valid !== 1'b0) $display("FAIL basic_ack_clear: got %b want 0", rx_valid); else n_pass++;
        ack_pulse();
        n_checks++; if (rx_valid !== 1'b0 || rx_data !== 8'hA5) $display("FAIL basic_ack_idle: valid %b data %h want 0 a5", rx_valid, rx_data); else n_pass++;
    endtask

    task automatic test_glitch();
        int ferr0;
        ferr0 = ferr_cnt;
        wait_tick();
        rxd = 1'b0;
        repeat (4) wait_tick();
        rxd = 1'b1;
        n_checks++; if (rx_busy !== 1'b1) $display("FAIL glitch_busy_start: got %b want 1", rx_busy); else n_pass++;
        repeat (4) wait_tick();
        n_checks++; if (rx_busy !== 1'b1) $display("FAIL glitch_busy_t8: got %b want 1", rx_busy); else n_pass++;
        wait_tick();
        n_checks++; if (rx_busy !== 1'b0) $display("FAIL glitch_idle_t9: got %b want 0", rx_busy); else n_pass++;
        repeat (40) wait_tick();
        n_checks++; if (rx_valid !== 1'b0 || rx_busy !== 1'b0) $display("FAIL glitch_quiet: valid %b busy %b want 0 0", rx_valid, rx_busy); else n_pass++;
        n_checks++; if (ferr_cnt != ferr0) $display("FAIL glitch_ferr: got %0d pulses want 0", ferr_cnt - ferr0); else n_pass++;
    endtask

    task automatic test_break();
        int ferr0;
        int r0;
        ferr0 = ferr_cnt; r0 = vld_rises;
        drive_frame(8'h3C, 1'b0);
        n_checks++; if (ferr_cnt != ferr0 + 1) $display("FAIL break_ferr: got %0d pulses want 1", ferr_cnt - ferr0); else n_pass++;
        n_checks++; if (rx_valid !== 1'b0) $display("FAIL break_valid: got %b want 0", rx_valid); else n_pass++;
        n_checks++; if (rx_data !== 8'hA5) $display("FAIL break_data_kept: got %h want a5", rx_data); else n_pass++;
        n_checks++; if (rx_busy !== 1'b1) $display("FAIL break_busy: got %b want 1", rx_busy); else n_pass++;
        repeat (24) wait_tick();
        n_checks++; if (rx_busy !== 1'b1 || ferr_cnt != ferr0 + 1 || vld_rises != r0) $display("FAIL break_hold: busy %b pulses %0d rises %0d want 1 1 0", rx_busy, ferr_cnt - ferr0, vld_rises - r0); else n_pass++;
        rxd = 1'b1;
        repeat (2) wait_tick();
        n_checks++; if (rx_busy !== 1'b0) $display("FAIL break_release: got %b want 0", rx_busy); else n_pass++;
        drive_frame(8'h55, 1'b1);
        n_checks++; if (rx_data !== 8'h55 || rx_valid !== 1'b1) $display("FAIL break_next: data %h valid %b want 55 1", rx_data, rx_valid); else n_pass++;
        n_checks++; if (ferr_cnt != ferr0 + 1) $display("FAIL break_next_ferr: got %0d pulses want 1", ferr_cnt - ferr0); else n_pass++;
        ack_pulse();
    endtask

    task automatic test_back_to_back();
        int r0;
        int seq;
        bit hit;
        r0 = vld_rises;
        drive_frame(8'h11, 1'b1);
        drive_frame(8'h22, 1'b1);
        n_checks++; if (rx_data !== 8'h22) $display("FAIL b2b_data: got %h want 22", rx_data); else n_pass++;
        n_checks++; if (rx_valid !== 1'b1) $display("FAIL b2b_valid: got %b want 1", rx_valid); else n_pass++;
        n_checks++; if (overrun !== 1'b1) $display("FAIL b2b_overrun: got %b want 1", overrun); else n_pass++;
        n_checks++; if (vld_rises != r0 + 1) $display("FAIL b2b_rises: got %0d want 1", vld_rises - r0); else n_pass++;
        ack_pulse();
        n_checks++; if (rx_valid !== 1'b0 || overrun !== 1'b0) $display("FAIL b2b_ack: valid %b overrun %b want 0 0", rx_valid, overrun); else n_pass++;

        drive_frame(8'h11, 1'b1);
        n_checks++; if (rx_data !== 8'h11 || rx_valid !== 1'b1 || overrun !== 1'b0) $display("FAIL b2b_first: data %h valid %b overrun %b want 11 1 0", rx_data, rx_valid, overrun); else n_pass++;
        seq = frame_seq + 1;
        hit = 1'b0;
        fork
            drive_frame(8'h22, 1'b1);
            begin
                for (int c = 0; c < 2000 && !hit; c++) begin
                    @(negedge clk);
                    if (frame_seq == seq && rxen && tick_no == frame_t0 + 153) begin
                        rx_ack = 1'b1;
                        @(negedge clk);
                        rx_ack = 1'b0;
                        hit = 1'b1;
                    end
                end
            end
        join
        n_checks++; if (hit !== 1'b1) $display("FAIL b2b_ack_slot: got %b want 1 (completion tick not reached)", hit); else n_pass++;
        n_checks++; if (rx_data !== 8'h22 || rx_valid !== 1'b1) $display("FAIL b2b_same_cycle: data %h valid %b want 22 1", rx_data, rx_valid); else n_pass++;
        n_checks++; if (overrun !== 1'b0) $display("FAIL b2b_same_cycle_overrun: got %b want 0", overrun); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int ferr0;
        ferr0 = ferr_cnt;
        n_checks++; if (rx_valid !== 1'b1) $display("FAIL rstmid_pre_valid: got %b want 1", rx_valid); else n_pass++;
        wait_tick();
        rxd = 1'b0;
        repeat (16) wait_tick();
        for (int i = 0; i < 4; i++) begin
            rxd = 1'b1;
            repeat (16) wait_tick();
        end
        rxd = 1'b1;
        repeat (8) wait_tick();
        n_checks++; if (rx_busy !== 1'b1) $display("FAIL rstmid_busy: got %b want 1", rx_busy); else n_pass++;
        @(negedge clk);
        n_rst = 1'b0;
        @(negedge clk);
        n_checks++; if (rx_data !== 8'h00 || rx_valid !== 1'b0) $display("FAIL rstmid_out: data %h valid %b want 00 0", rx_data, rx_valid); else n_pass++;
        n_checks++; if (overrun !== 1'b0 || frame_err !== 1'b0 || rx_busy !== 1'b0) $display("FAIL rstmid_flags: overrun %b ferr %b busy %b want 0 0 0", overrun, frame_err, rx_busy); else n_pass++;
        @(negedge clk);
        n_rst = 1'b1;
        repeat (100) wait_tick();
        n_checks++; if (rx_busy !== 1'b0 || rx_valid !== 1'b0 || rx_data !== 8'h00) $display("FAIL rstmid_aborted: busy %b valid %b data %h want 0 0 00", rx_busy, rx_valid, rx_data); else n_pass++;
        drive_frame(8'h81, 1'b1);
        n_checks++; if (rx_data !== 8'h81 || rx_valid !== 1'b1) $display("FAIL rstmid_next: data %h valid %b want 81 1", rx_data, rx_valid); else n_pass++;
        n_checks++; if (vld_rise_tick != frame_t0 + 153 || ferr_cnt != ferr0) $display("FAIL rstmid_next_timing: tick %0d ferr %0d want %0d 0", vld_rise_tick, ferr_cnt - ferr0, frame_t0 + 153); else n_pass++;
        ack_pulse();
    endtask

    task automatic test_loopback();
        logic [7:0] tx_bytes [3];
        logic [7:0] got [$];
        logic [9:0] sh;
        int ferr0;
        tx_bytes[0] = 8'h00; tx_bytes[1] = 8'hFF; tx_bytes[2] = 8'h5A;
        ferr0 = ferr_cnt;
        fork
            begin
                // Transmitter bit clock: one line bit per 16 receiver ticks.
                wait_tick();
                for (int b = 0; b < 3; b++) begin
                    sh = {1'b1, tx_bytes[b], 1'b0};
                    for (int k = 0; k < 10; k++) begin
                        rxd = sh[0];
                        sh = sh >> 1;
                        repeat (16) wait_tick();
                    end
                end
                repeat (20) wait_tick();
            end
            begin
                for (int c = 0; c < 8000 && got.size() < 3; c++) begin
                    @(negedge clk);
                    if (rx_ack) rx_ack = 1'b0;
                    else if (rx_valid) begin
                        got.push_back(rx_data);
                        rx_ack = 1'b1;
                    end
                end
                @(negedge clk);
                rx_ack = 1'b0;
            end
        join
        n_checks++; if (got.size() != 3) $display("FAIL loop_count: got %0d bytes want 3", got.size()); else n_pass++;
        for (int i = 0; i < got.size(); i++) begin
            n_checks++; if (got[i] !== tx_bytes[i]) $display("FAIL loop_byte%0d: got %h want %h", i, got[i], tx_bytes[i]); else n_pass++;
        end
        n_checks++; if (ferr_cnt != ferr0 || overrun !== 1'b0) $display("FAIL loop_errors: ferr %0d overrun %b want 0 0", ferr_cnt - ferr0, overrun); else n_pass++;
        n_checks++; if (rx_valid !== 1'b0) $display("FAIL loop_drained: valid %b want 0", rx_valid); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_break();
        test_back_to_back();
        test_reset_mid();
        test_loopback();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
